regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multiport integer register file for the superscalar RV32I core, the successor to the fixed 2-write/4-read register file. It generalises width, write-port count and read-port count while keeping the XOR-banked (one bank per write port) storage scheme. It adds three behaviours: asynchronous clear of architectural state, optional write-to-read bypass, and a per-register busy scoreboard for issue-stage hazard checks. It sits between decode/issue (reads, allocation) and writeback (writes).

## Interface
Parameters:
- XLEN, 32: data width.
- NREGS, 32: register count; address width AW = $clog2(NREGS).
- NW, 2: write ports, each backed by one XOR bank; legal range 1..4.
- NR, 4: read ports; legal range 1..8.
- BYPASS, 1: 1 = same-cycle write data forwarded to reads; 0 = reads see only stored state.

Ports (multi-port buses are flattened, with port k at slice [k*W +: W]):
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- rs  in  NR*AW  read addresses.
- rdata  out  NR*XLEN  read data, combinational.
- rbusy  out  NR  busy flag of each read address, combinational.
- we  in  NW  write enables.
- wa  in  NW*AW  write addresses.
- wd  in  NW*XLEN  write data.
- alloc_en  in  NW  reserve a destination (mark busy).
- alloc_rd  in  NW*AW  destination to reserve.

## Operation
- Storage: bank p holds mem_p[NREGS]. The value of register a is the XOR of all banks at a, gated by valid[a].
- rdata_k: 0 if rs_k==0 or valid[rs_k]==0; otherwise the XOR of banks.
- Write port p is effective when we[p] && wa[p]!=0 and no lower-index port j<p is effective with wa[j]==wa[p]. Lower index wins; the losing port's write is dropped.
- On an effective write, mem_p[a] <= wd[p] ^ (XOR of mem_q[a] for q≠p) and valid[a] <= 1. Stale bank contents after reset are cancelled by this formula; no memory clear is required.
- BYPASS=1: if rs_k matches an effective write this cycle, rdata_k = that port's wd (winning port). rs_k==0 still returns 0.
- Scoreboard busy[NREGS]:
  - alloc_en[p] with alloc_rd[p]!=0 sets busy.
  - An effective write to a clears busy, unless a is allocated in the same cycle; allocation wins because a new producer exists.
  - busy[0] is always 0.
- rbusy_k = busy[rs_k]. With BYPASS=1, rbusy_k is 0 if rs_k is being written this cycle and not being allocated this cycle.
- Duplicate alloc_rd across ports is legal and idempotent.

## Timing
- Reset (RST_N low, asynchronous): valid and busy cleared to 0 immediately. Every rdata reads 0 and every rbusy reads 0 while reset is held and after release, until the next write.
- Bank memories are not reset.
- Write latency:
  - BYPASS=0: data visible on rdata in the cycle after the edge.
  - BYPASS=1: data visible combinationally in the same cycle.
- Alloc-to-busy latency: 1 edge. No combinational path from alloc_en to rbusy.
- Reset asserted mid-cycle discards that cycle's writes and allocations.

## Structure
- Shared package rv_pkg: XLEN, REG_AW, and the constant REG_ZERO = 0.
- Sub-module regfile_mp_bank (one XOR bank):
  - 1 write port; NW-1 cross-read ports for XOR data; NR read ports.
  - Generated NW times.
- Top level holds:
  - port-priority resolution;
  - valid and busy vectors (flops with async clear);
  - read XOR reduction and bypass muxes.

## Test plan
- Reset then read: release RST_N; rs={1,2,3,31} -> rdata all 0, rbusy all 0.
- Basic write: we[0], wa=5, wd=0xDEADBEEF.
  - BYPASS=0: read x5 next cycle -> 0xDEADBEEF.
  - BYPASS=1: same-cycle read of x5 -> 0xDEADBEEF.
- Cross-bank overwrite: port0 writes x7=0x11111111; next cycle port1 writes x7=0x22222222 -> x7 reads 0x22222222 on all read ports.
- Same-address conflict: port0 and port1 both write x9 (0xAAAA0000, 0x0000BBBB) -> x9=0xAAAA0000. Writes to x0 from any port -> x0 reads 0.
- Scoreboard: alloc x4 -> rbusy=1 next cycle; later writeback x4 with simultaneous alloc x4 -> stays busy; writeback alone -> rbusy 0.
- Async reset mid-run: after writing x3=0x5, pulse RST_N low between edges -> x3 reads 0 and busy clears immediately. A new write x3=0x6 then reads 0x6 despite stale bank contents.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I core constants: data width, register-address width and the x0 index.
// Also holds the cross-read port numbering used between XOR banks.
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // Slot that write port p occupies in bank q's cross-read list (bank q skips itself).
  function automatic int xport_idx(input int p, input int q);
    return (p < q) ? p : p - 1;
  endfunction

endpackage

// File: rtl/regfile_mp_bank.sv
// One XOR storage bank: a single write port, cross-read ports feeding the other
// banks' write-data XOR, and one read port per register-file read port.
module regfile_mp_bank #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NR    = 4,
  parameter int NX    = 1,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic               CLK,
  input  logic               we,
  input  logic [AW-1:0]      wa,
  input  logic [XLEN-1:0]    wd,
  input  logic [NX*AW-1:0]   xa,
  output logic [NX*XLEN-1:0] xd,
  input  logic [NR*AW-1:0]   ra,
  output logic [NR*XLEN-1:0] rd
);

  // Contents are deliberately not reset; the XOR write formula cancels stale data.
  logic [XLEN-1:0] mem_q [NREGS];

  always_ff @(posedge CLK) begin
    if (we) mem_q[wa] <= wd;
  end

  for (genvar i = 0; i < NX; i++) begin : g_xrd
    assign xd[i*XLEN +: XLEN] = mem_q[xa[i*AW +: AW]];
  end

  for (genvar k = 0; k < NR; k++) begin : g_rd
    assign rd[k*XLEN +: XLEN] = mem_q[ra[k*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multiport XOR-banked integer register file with valid tracking, optional
// write-to-read bypass and a per-register busy scoreboard.
module regfile_mp #(
  parameter int XLEN   = rv_pkg::XLEN,
  parameter int NREGS  = rv_pkg::NREGS,
  parameter int NW     = 2,
  parameter int NR     = 4,
  parameter int BYPASS = 1
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [NR*$clog2(NREGS)-1:0]  rs,
  output logic [NR*XLEN-1:0]           rdata,
  output logic [NR-1:0]                rbusy,
  input  logic [NW-1:0]                we,
  input  logic [NW*$clog2(NREGS)-1:0]  wa,
  input  logic [NW*XLEN-1:0]           wd,
  input  logic [NW-1:0]                alloc_en,
  input  logic [NW*$clog2(NREGS)-1:0]  alloc_rd
);
  import rv_pkg::*;

  localparam int AW = $clog2(NREGS);
  localparam int NX = (NW > 1) ? NW - 1 : 1;
  localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

  logic [NW-1:0]        wr_eff;
  logic [NREGS-1:0]     valid_q, valid_d, busy_q, busy_d;
  logic [NREGS-1:0]     wr_mask, al_mask;
  logic [NW*XLEN-1:0]   bank_wd;
  logic [NX*AW-1:0]     bank_xa [NW];
  logic [NX*XLEN-1:0]   bank_xd [NW];
  logic [NR*XLEN-1:0]   bank_rd [NW];
  logic [AW-1:0]        ra_c;
  logic [XLEN-1:0]      x_c;
  logic                 rb_c;

  // Lower-index port wins a same-address conflict; writes are dropped while in reset.
  always_comb begin
    wr_eff = '0;
    for (int p = 0; p < NW; p++) begin
      wr_eff[p] = RST_N && we[p] && (wa[p*AW +: AW] != ZERO_A);
      for (int j = 0; j < p; j++) begin
        if (wr_eff[j] && (wa[j*AW +: AW] == wa[p*AW +: AW])) wr_eff[p] = 1'b0;
      end
    end
  end

  always_comb begin
    for (int q = 0; q < NW; q++) begin
      bank_xa[q] = '0;
      for (int p = 0; p < NW; p++) begin
        if (p != q) bank_xa[q][xport_idx(p, q)*AW +: AW] = wa[p*AW +: AW];
      end
    end
  end

  // Store wd ^ (other banks) so the XOR across all banks reproduces wd.
  always_comb begin
    bank_wd = wd;
    for (int p = 0; p < NW; p++) begin
      for (int q = 0; q < NW; q++) begin
        if (q != p) bank_wd[p*XLEN +: XLEN] ^= bank_xd[q][xport_idx(p, q)*XLEN +: XLEN];
      end
    end
  end

  for (genvar p = 0; p < NW; p++) begin : g_bank
    regfile_mp_bank #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .NR    (NR),
      .NX    (NX),
      .AW    (AW)
    ) u_bank (
      .CLK (CLK),
      .we  (wr_eff[p]),
      .wa  (wa[p*AW +: AW]),
      .wd  (bank_wd[p*XLEN +: XLEN]),
      .xa  (bank_xa[p]),
      .xd  (bank_xd[p]),
      .ra  (rs),
      .rd  (bank_rd[p])
    );
  end

  always_comb begin
    wr_mask = '0;
    al_mask = '0;
    for (int p = 0; p < NW; p++) begin
      if (wr_eff[p]) wr_mask[wa[p*AW +: AW]] = 1'b1;
      if (RST_N && alloc_en[p]) al_mask[alloc_rd[p*AW +: AW]] = 1'b1;
    end
    al_mask[0] = 1'b0;
    valid_d = valid_q | wr_mask;
    // A same-cycle allocation keeps the register busy: a newer producer exists.
    busy_d  = (busy_q & ~wr_mask) | al_mask;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q <= '0;
      busy_q  <= '0;
    end else begin
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra_c  = '0;
    x_c   = '0;
    rb_c  = 1'b0;
    for (int k = 0; k < NR; k++) begin
      ra_c = rs[k*AW +: AW];
      x_c  = '0;
      for (int p = 0; p < NW; p++) x_c ^= bank_rd[p][k*XLEN +: XLEN];
      if (!valid_q[ra_c]) x_c = '0;
      rb_c = busy_q[ra_c];
      if (BYPASS != 0) begin
        for (int p = NW - 1; p >= 0; p--) begin
          if (wr_eff[p] && (wa[p*AW +: AW] == ra_c)) x_c = wd[p*XLEN +: XLEN];
        end
        if (wr_mask[ra_c] && !al_mask[ra_c]) rb_c = 1'b0;
      end
      if (ra_c == ZERO_A) x_c = '0;
      rdata[k*XLEN +: XLEN] = x_c;
      rbusy[k] = rb_c;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed plus random checks of regfile_mp, with and without bypass, against an
// architectural model (register values, valid and busy flags).
module tb_regfile_mp;
  import rv_pkg::*;

  localparam int NW = 2;
  localparam int NR = 4;
  localparam int AW = REG_AW;

  logic                CLK = 1'b0;
  logic                RST_N;
  logic [NR*AW-1:0]    rs;
  logic [NW-1:0]       we, alloc_en;
  logic [NW*AW-1:0]    wa, alloc_rd;
  logic [NW*XLEN-1:0]  wd;
  logic [NR*XLEN-1:0]  rdata_nb, rdata_bp;
  logic [NR-1:0]       rbusy_nb, rbusy_bp;

  regfile_mp #(.NW(NW), .NR(NR), .BYPASS(0)) u_nb (
    .CLK(CLK), .RST_N(RST_N), .rs(rs), .rdata(rdata_nb), .rbusy(rbusy_nb),
    .we(we), .wa(wa), .wd(wd), .alloc_en(alloc_en), .alloc_rd(alloc_rd));

  regfile_mp #(.NW(NW), .NR(NR), .BYPASS(1)) u_bp (
    .CLK(CLK), .RST_N(RST_N), .rs(rs), .rdata(rdata_bp), .rbusy(rbusy_bp),
    .we(we), .wa(wa), .wd(wd), .alloc_en(alloc_en), .alloc_rd(alloc_rd));

  always #5 CLK = ~CLK;

  logic [XLEN-1:0] m_val [NREGS];
  bit              m_valid [NREGS];
  bit              m_busy [NREGS];
  bit              c_wr [NREGS];
  logic [XLEN-1:0] c_wd [NREGS];
  bit              c_al [NREGS];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] nb(input int k);
    return rdata_nb[k*XLEN +: XLEN];
  endfunction

  function automatic logic [XLEN-1:0] bp(input int k);
    return rdata_bp[k*XLEN +: XLEN];
  endfunction

  function automatic logic [XLEN-1:0] model_rd(input int a);
    return (a != 0 && m_valid[a]) ? m_val[a] : '0;
  endfunction

  task automatic idle();
    we = '0; wa = '0; wd = '0; alloc_en = '0; alloc_rd = '0;
  endtask

  task automatic set_w(input int p, input int a, input logic [XLEN-1:0] d);
    we[p] = 1'b1; wa[p*AW +: AW] = AW'(a); wd[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_a(input int p, input int a);
    alloc_en[p] = 1'b1; alloc_rd[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_rs(input int k, input int a);
    rs[k*AW +: AW] = AW'(a);
  endtask

  // Resolve this cycle's writes and allocations from the rules: first port to claim an address wins.
  task automatic plan();
    int a;
    for (int i = 0; i < NREGS; i++) begin c_wr[i] = 0; c_al[i] = 0; c_wd[i] = '0; end
    for (int p = 0; p < NW; p++) begin
      a = int'(wa[p*AW +: AW]);
      if (we[p] && a != 0 && !c_wr[a]) begin c_wr[a] = 1; c_wd[a] = wd[p*XLEN +: XLEN]; end
      a = int'(alloc_rd[p*AW +: AW]);
      if (alloc_en[p] && a != 0) c_al[a] = 1;
    end
  endtask

  task automatic check_reads();
    int a;
    logic [XLEN-1:0] e_nb, e_bp;
    for (int k = 0; k < NR; k++) begin
      a = int'(rs[k*AW +: AW]);
      e_nb = model_rd(a);
      e_bp = (a == 0) ? '0 : (c_wr[a] ? c_wd[a] : e_nb);
      check($sformatf("rdata_nb[%0d] x%0d", k, a), nb(k), e_nb);
      check($sformatf("rdata_bp[%0d] x%0d", k, a), bp(k), e_bp);
      check($sformatf("rbusy_nb[%0d] x%0d", k, a), XLEN'(rbusy_nb[k]), XLEN'(m_busy[a]));
      check($sformatf("rbusy_bp[%0d] x%0d", k, a), XLEN'(rbusy_bp[k]),
            XLEN'(m_busy[a] && !(c_wr[a] && !c_al[a])));
    end
  endtask

  // Called just after a falling edge with inputs driven; returns after the next falling edge.
  task automatic step();
    plan();
    #1;
    check_reads();
    @(posedge CLK);
    for (int a = 1; a < NREGS; a++) begin
      if (c_wr[a]) begin m_val[a] = c_wd[a]; m_valid[a] = 1; end
      if (c_al[a]) m_busy[a] = 1;
      else if (c_wr[a]) m_busy[a] = 0;
    end
    @(negedge CLK);
  endtask

  task automatic reset_pulse();
    RST_N = 1'b0;
    #1;
    for (int k = 0; k < NR; k++) begin
      check($sformatf("rst_pulse rdata_nb[%0d]", k), nb(k), '0);
      check($sformatf("rst_pulse rdata_bp[%0d]", k), bp(k), '0);
      check($sformatf("rst_pulse rbusy_nb[%0d]", k), XLEN'(rbusy_nb[k]), '0);
      check($sformatf("rst_pulse rbusy_bp[%0d]", k), XLEN'(rbusy_bp[k]), '0);
    end
    for (int a = 0; a < NREGS; a++) begin m_valid[a] = 0; m_busy[a] = 0; end
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0;
    idle();
    rs = '0;
    set_rs(0, 1); set_rs(1, 2); set_rs(2, 3); set_rs(3, 31);
    for (int a = 0; a < NREGS; a++) begin m_val[a] = '0; m_valid[a] = 0; m_busy[a] = 0; end
    repeat (2) @(negedge CLK);
    for (int k = 0; k < NR; k++) begin
      check($sformatf("rst_hold rdata_bp[%0d]", k), bp(k), '0);
      check($sformatf("rst_hold rbusy_bp[%0d]", k), XLEN'(rbusy_bp[k]), '0);
    end
    RST_N = 1'b1;
    step();

    // Basic write to x5
    set_w(0, 5, 32'hDEADBEEF); set_rs(0, 5);
    #1;
    check("wr_x5 same-cycle bp", bp(0), 32'hDEADBEEF);
    check("wr_x5 same-cycle nb", nb(0), 32'h0);
    step();
    idle();
    check("wr_x5 next-cycle nb", nb(0), 32'hDEADBEEF);
    step();

    // Cross-bank overwrite of x7
    set_w(0, 7, 32'h11111111);
    step();
    idle(); set_w(1, 7, 32'h22222222);
    step();
    idle();
    for (int k = 0; k < NR; k++) set_rs(k, 7);
    #1;
    for (int k = 0; k < NR; k++) begin
      check($sformatf("xbank x7 nb[%0d]", k), nb(k), 32'h22222222);
      check($sformatf("xbank x7 bp[%0d]", k), bp(k), 32'h22222222);
    end
    step();

    // Same-address conflict and writes to x0
    set_w(0, 9, 32'hAAAA0000); set_w(1, 9, 32'h0000BBBB); set_rs(0, 9);
    #1;
    check("conflict x9 bp", bp(0), 32'hAAAA0000);
    step();
    idle();
    check("conflict x9 nb", nb(0), 32'hAAAA0000);
    step();
    set_w(0, 0, 32'h12345678); set_w(1, 0, 32'h9ABCDEF0); set_rs(0, 0);
    #1;
    check("x0 write bp", bp(0), 32'h0);
    step();
    idle();
    check("x0 write nb", nb(0), 32'h0);
    step();

    // Scoreboard on x4
    set_a(0, 4); set_rs(0, 4);
    #1;
    check("alloc x4 no comb path", XLEN'(rbusy_bp[0]), 32'h0);
    step();
    idle();
    check("alloc x4 busy nb", XLEN'(rbusy_nb[0]), 32'h1);
    step();
    set_w(0, 4, 32'h44); set_a(1, 4);
    step();
    idle();
    check("wb+alloc x4 busy", XLEN'(rbusy_nb[0]), 32'h1);
    set_w(0, 4, 32'h45);
    #1;
    check("wb x4 bp clears now", XLEN'(rbusy_bp[0]), 32'h0);
    check("wb x4 nb still busy", XLEN'(rbusy_nb[0]), 32'h1);
    step();
    idle();
    check("wb x4 cleared nb", XLEN'(rbusy_nb[0]), 32'h0);
    step();

    // Async reset mid-run, then rewrite x3 over stale bank contents
    set_w(0, 3, 32'h5); set_a(1, 3);
    step();
    idle(); set_rs(0, 3);
    #1;
    check("x3 before reset", nb(0), 32'h5);
    check("x3 busy before reset", XLEN'(rbusy_nb[0]), 32'h1);
    reset_pulse();
    step();
    set_w(1, 3, 32'h6);
    step();
    idle();
    check("x3 after reset rewrite", nb(0), 32'h6);
    step();

    // Random traffic with occasional mid-cycle reset
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int p = 0; p < NW; p++) begin
        if ($urandom_range(0, 2) != 0)
          set_w(p, ($urandom_range(0, 3) == 0) ? $urandom_range(0, NREGS - 1) : $urandom_range(0, 7), $urandom);
        if ($urandom_range(0, 2) == 0)
          set_a(p, $urandom_range(0, 7));
      end
      for (int k = 0; k < NR; k++)
        set_rs(k, ($urandom_range(0, 3) == 0) ? $urandom_range(0, NREGS - 1) : $urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) reset_pulse();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
